// File: rtl/logic_unit_seq.sv
// Sliced, registered bitwise logic unit with valid/ready handshakes on both sides.
// Optional zero/parity result flags are enabled by defining LOGIC_FLAGS_EN.
module logic_unit_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SLICE = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out
`ifdef LOGIC_FLAGS_EN
    ,
    output logic             zero,
    output logic             parity
`endif
);

    localparam int unsigned N  = WIDTH / SLICE;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    generate
        if ((WIDTH % SLICE) != 0) begin : g_bad_slice
            $error("logic_unit_seq: WIDTH must be a multiple of SLICE");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                   state, state_nxt;
    logic [CW-1:0]            cnt, cnt_nxt;
    logic [N-1:0][SLICE-1:0]  a_q, a_nxt;
    logic [N-1:0][SLICE-1:0]  b_q, b_nxt;
    logic [N-1:0][SLICE-1:0]  res_q, res_nxt;
    logic [2:0]               op_q, op_nxt;
    logic                     out_valid_nxt;
    logic [SLICE-1:0]         slice_c;
    logic                     last_c;
`ifdef LOGIC_FLAGS_EN
    logic                     zero_q, zero_nxt;
    logic                     parity_q, parity_nxt;
`endif

    // One slice of the selected bitwise operation.
    function automatic logic [SLICE-1:0] slice_op(input logic [2:0] o,
                                                  input logic [SLICE-1:0] x,
                                                  input logic [SLICE-1:0] y);
        slice_op = '0;
        case (o)
            3'b000: slice_op = x & y;
            3'b001: slice_op = x | y;
            3'b010: slice_op = x ^ y;
            3'b011: slice_op = ~(x | y);
            3'b100: slice_op = ~(x & y);
            3'b101: slice_op = ~(x ^ y);
            3'b110: slice_op = x & ~y;
            3'b111: slice_op = ~x;
            default: slice_op = '0;
        endcase
    endfunction

    assign slice_c   = slice_op(op_q, a_q[cnt], b_q[cnt]);
    assign last_c    = (cnt == CW'(N - 1));
    assign in_ready  = (state == IDLE) && !rst;
    assign out       = res_q;
`ifdef LOGIC_FLAGS_EN
    assign zero      = zero_q;
    assign parity    = parity_q;
`endif

    // Next-state and datapath update.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        a_nxt         = a_q;
        b_nxt         = b_q;
        op_nxt        = op_q;
        res_nxt       = res_q;
        out_valid_nxt = out_valid;
`ifdef LOGIC_FLAGS_EN
        zero_nxt      = zero_q;
        parity_nxt    = parity_q;
`endif
        case (state)
            IDLE: begin
                if (in_valid) begin
                    a_nxt     = a;
                    b_nxt     = b;
                    op_nxt    = op;
                    res_nxt   = '0;
                    cnt_nxt   = '0;
                    state_nxt = RUN;
`ifdef LOGIC_FLAGS_EN
                    zero_nxt   = 1'b1;
                    parity_nxt = 1'b0;
`endif
                end
            end
            RUN: begin
                res_nxt[cnt] = slice_c;
`ifdef LOGIC_FLAGS_EN
                zero_nxt   = zero_q & (slice_c == '0);
                parity_nxt = parity_q ^ (^slice_c);
`endif
                if (last_c) begin
                    cnt_nxt       = '0;
                    out_valid_nxt = 1'b1;
                    state_nxt     = DONE;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_nxt = 1'b0;
                    state_nxt     = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any partial result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            res_q     <= '0;
            out_valid <= 1'b0;
`ifdef LOGIC_FLAGS_EN
            zero_q    <= 1'b0;
            parity_q  <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            a_q       <= a_nxt;
            b_q       <= b_nxt;
            op_q      <= op_nxt;
            res_q     <= res_nxt;
            out_valid <= out_valid_nxt;
`ifdef LOGIC_FLAGS_EN
            zero_q    <= zero_nxt;
            parity_q  <= parity_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_logic_unit_seq.sv
// Randomized and directed bench for logic_unit_seq against a transaction-level model,
// plus a second single-slice (WIDTH=16, SLICE=16) instance.
module tb_logic_unit_seq;

    localparam int unsigned W  = 32;
    localparam int unsigned S  = 8;
    localparam int          N  = int'(W / S);
    localparam int unsigned W2 = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic          in_valid = 1'b0, out_ready = 1'b0;
    logic [W-1:0]  a = '0, b = '0;
    logic [2:0]    op = '0;
    logic          in_ready, out_valid;
    logic [W-1:0]  out;
    logic          zero1, parity1;

    logic          in_valid2 = 1'b0, out_ready2 = 1'b0;
    logic [W2-1:0] a2 = '0, b2 = '0;
    logic [2:0]    op2 = '0;
    logic          in_ready2, out_valid2;
    logic [W2-1:0] out2;
    logic          zero2, parity2;

    logic_unit_seq #(.WIDTH(W), .SLICE(S)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready), .out(out)
`ifdef LOGIC_FLAGS_EN
        , .zero(zero1), .parity(parity1)
`endif
    );

    logic_unit_seq #(.WIDTH(W2), .SLICE(W2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
        .a(a2), .b(b2), .op(op2), .out_valid(out_valid2), .out_ready(out_ready2), .out(out2)
`ifdef LOGIC_FLAGS_EN
        , .zero(zero2), .parity(parity2)
`endif
    );

`ifndef LOGIC_FLAGS_EN
    assign zero1   = 1'b0;
    assign parity1 = 1'b0;
    assign zero2   = 1'b0;
    assign parity2 = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out, expected DUT handshake", name);
    endtask

    function automatic logic [W-1:0] model(input logic [2:0] o, input logic [W-1:0] x,
                                           input logic [W-1:0] y);
        case (o)
            3'd0:    model = x & y;
            3'd1:    model = x | y;
            3'd2:    model = x ^ y;
            3'd3:    model = ~(x | y);
            3'd4:    model = ~(x & y);
            3'd5:    model = ~(x ^ y);
            3'd6:    model = x & ~y;
            default: model = ~x;
        endcase
    endfunction

    // Outstanding operation: expected result and the edge it was accepted on.
    typedef struct {
        logic [W-1:0] res;
        int           acc;
    } txn_t;

    txn_t         q[$];
    int           edges  = 0;
    logic [W-1:0] m_last = '0;

    // Transaction model: accept when idle, result due N edges later, retire on out_ready.
    always @(posedge clk) begin
        bit   idle_pre;
        bit   due;
        txn_t t;
        idle_pre = (q.size() == 0);
        due      = (q.size() > 0) && ((edges - q[0].acc) >= N);
        edges++;
        if (rst) begin
            q.delete();
            m_last = '0;
        end else begin
            if (due && out_ready) begin
                m_last = q[0].res;
                void'(q.pop_front());
            end
            if (in_valid && idle_pre) begin
                t.res = model(op, a, b);
                t.acc = edges;
                q.push_back(t);
            end
        end
    end

    // Cycle-by-cycle comparison of the main instance against the model.
    always @(negedge clk) begin
        bit due;
        due = (q.size() > 0) && ((edges - q[0].acc) >= N);
        check("in_ready", W'(in_ready), W'((q.size() == 0) && !rst));
        check("out_valid", W'(out_valid), W'(due));
        if (due) begin
            check("out", out, q[0].res);
`ifdef LOGIC_FLAGS_EN
            check("zero", W'(zero1), W'(q[0].res == '0));
            check("parity", W'(parity1), W'(^q[0].res));
`endif
        end else if (q.size() == 0) begin
            check("out_idle", out, m_last);
        end
    end

    task automatic nxt();
        @(negedge clk);
        #1;
    endtask

    // scr: 0 leave operands, 1 drive a=0 after accept, 2 randomize inputs while busy.
    task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input bit use_lit, input logic [W-1:0] lit, input int hold,
                          input bit early, input int scr);
        int t;
        t = 0;
        while (!in_ready && t < 40) begin
            nxt();
            t++;
        end
        if (!in_ready) begin
            timeout_fail("accept");
            return;
        end
        in_valid  = 1'b1;
        a         = x;
        b         = y;
        op        = o;
        out_ready = early;
        nxt();
        in_valid = 1'b0;
        if (scr == 1) a = '0;
        if (scr == 2) begin
            in_valid = 1'($urandom_range(0, 1));
            a        = W'($urandom);
            b        = W'($urandom);
            op       = 3'($urandom);
        end
        t = 0;
        while (!out_valid && t < 4 * N + 8) begin
            nxt();
            t++;
        end
        in_valid = 1'b0;
        if (!out_valid) begin
            timeout_fail("result");
            out_ready = 1'b0;
            return;
        end
        if (use_lit) check("result_lit", out, lit);
        if (early) begin
            nxt();
            out_ready = 1'b0;
            check("single_cycle_valid", W'(out_valid), '0);
        end else begin
            for (int i = 0; i < hold; i++) begin
                nxt();
                check("hold_valid", W'(out_valid), W'(1));
                check("hold_in_ready", W'(in_ready), '0);
                if (use_lit) check("hold_out", out, lit);
            end
            out_ready = 1'b1;
            nxt();
            out_ready = 1'b0;
            check("post_valid", W'(out_valid), '0);
            check("post_in_ready", W'(in_ready), W'(1));
        end
    endtask

    // Single-slice instance: result one edge after accept.
    task automatic run2(input logic [2:0] o, input logic [W2-1:0] x, input logic [W2-1:0] y,
                        input logic [W2-1:0] lit, input bit zl, input bit pl);
        check("n1_in_ready", W'(in_ready2), W'(1));
        in_valid2 = 1'b1;
        a2        = x;
        b2        = y;
        op2       = o;
        nxt();
        in_valid2 = 1'b0;
        check("n1_run_valid", W'(out_valid2), '0);
        check("n1_run_in_ready", W'(in_ready2), '0);
        nxt();
        check("n1_valid", W'(out_valid2), W'(1));
        check("n1_out", W'(out2), W'(lit));
`ifdef LOGIC_FLAGS_EN
        check("n1_zero", W'(zero2), W'(zl));
        check("n1_parity", W'(parity2), W'(pl));
`else
        if (zl && pl) check("n1_flags_unused", W'(zero2), '0);
`endif
        out_ready2 = 1'b1;
        nxt();
        out_ready2 = 1'b0;
        check("n1_post_valid", W'(out_valid2), '0);
        check("n1_post_in_ready", W'(in_ready2), W'(1));
    endtask

    typedef struct {
        logic [2:0]   o;
        logic [W-1:0] res;
    } op_vec_t;

    initial begin
        op_vec_t vecs[8];
        vecs[0] = '{3'd0, 32'hF00005A0};
        vecs[1] = '{3'd1, 32'hFFF0AFF5};
        vecs[2] = '{3'd2, 32'h0FF0AA55};
        vecs[3] = '{3'd3, 32'h000F500A};
        vecs[4] = '{3'd4, 32'h0FFFFA5F};
        vecs[5] = '{3'd5, 32'hF00F55AA};
        vecs[6] = '{3'd6, 32'h00F0A005};
        vecs[7] = '{3'd7, 32'h0F0F5A5A};

        nxt();
        check("reset_out", out, '0);
        check("reset_valid", W'(out_valid), '0);
        check("reset_in_ready", W'(in_ready), '0);
        nxt();
        rst = 1'b0;
        nxt();

        run_op(3'd0, 32'hFFFFFFFF, 32'h0000FFFF, 1'b1, 32'h0000FFFF, 0, 1'b0, 0);
        run_op(3'd0, 32'hFFFFFFFF, 32'hFFFF0000, 1'b1, 32'hFFFF0000, 0, 1'b0, 0);
        run_op(3'd0, 32'h00000003, 32'h00000002, 1'b1, 32'h00000002, 0, 1'b0, 0);
        foreach (vecs[i])
            run_op(vecs[i].o, 32'hF0F0A5A5, 32'hFF000FF0, 1'b1, vecs[i].res, 1, 1'b0, 0);

        // Backpressure, operand change while busy, out_ready early.
        run_op(3'd2, 32'hDEADBEEF, 32'h0F0F0F0F, 1'b1, 32'hD1A2B1E0, 6, 1'b0, 0);
        run_op(3'd0, 32'h12345678, 32'hFFFFFFFF, 1'b1, 32'h12345678, 0, 1'b0, 1);
        run_op(3'd1, 32'h00FF00FF, 32'h0F000000, 1'b1, 32'h0FFF00FF, 0, 1'b1, 0);

        // Reset during the second RUN cycle.
        in_valid = 1'b1;
        a        = 32'hAAAAAAAA;
        b        = 32'h55555555;
        op       = 3'd1;
        nxt();
        in_valid = 1'b0;
        nxt();
        rst = 1'b1;
        nxt();
        rst = 1'b0;
        check("abort_out", out, '0);
        check("abort_valid", W'(out_valid), '0);
        run_op(3'd5, 32'h0000FFFF, 32'h00FF00FF, 1'b1, 32'hFF0000FF, 0, 1'b0, 0);

        for (int i = 0; i < 40; i++)
            run_op(3'($urandom), W'($urandom), W'($urandom), 1'b0, '0,
                   int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 2)));

        run2(3'd0, 16'h00FF, 16'hFF00, 16'h0000, 1'b1, 1'b0);
        run2(3'd1, 16'h00FF, 16'hFF00, 16'hFFFF, 1'b0, 1'b0);
        run2(3'd2, 16'h0001, 16'h0000, 16'h0001, 1'b0, 1'b1);

        nxt();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
